// File: rtl/wam_pkg.sv
// Shared constants and types for the key matrix scanner.
package wam_pkg;

    localparam int NUM_ROWS       = 3;
    localparam int NUM_COLS       = 3;
    localparam int NUM_KEYS       = 9;
    localparam int KEY_FIFO_DEPTH = 4;

    typedef logic [3:0] key_code_t;

    // Key index as used on key_code: row*NUM_COLS + col.
    function automatic key_code_t key_index(input logic [1:0] row, input logic [1:0] col);
        return key_code_t'(int'(row) * NUM_COLS + int'(col));
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Small FIFO of key codes. A push into a full FIFO is accepted only when a
// pop happens on the same cycle; data_out reads 0 while empty.
module key_event_fifo
    import wam_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  key_code_t data_in,
    output logic      full,
    input  logic      pop,
    output key_code_t data_out,
    output logic      empty
);

    localparam int AW = $clog2(KEY_FIFO_DEPTH);

    key_code_t        r_mem [KEY_FIFO_DEPTH];
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [AW:0]      r_cnt;
    logic             w_pop;
    logic             w_push;

    assign empty    = (r_cnt == '0);
    assign full     = (r_cnt == (AW+1)'(KEY_FIFO_DEPTH));
    assign w_pop    = pop & ~empty;
    assign w_push   = push & (~full | w_pop);
    assign data_out = empty ? '0 : r_mem[r_rd];

    // Storage write; contents are don't-care until pointed at by the count.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= data_in;
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/key_matrix_scanner.sv
// 3x3 key matrix scanner: column strobe, per-key debounce, press-event
// sequencer and event FIFO. Define WAM_ROW_SYNC_EN to route the row returns
// through a 2-flop synchronizer; otherwise rows are sampled directly.
module key_matrix_scanner
    import wam_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic [2:0] key_matrix_col,
    input  logic [2:0] key_matrix_row,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ready,
    output logic       key_overflow
);

    localparam int DW = $clog2(SCAN_DIV);

    logic [DW-1:0]          r_div;
    logic [1:0]             r_col;
    logic [NUM_KEYS-1:0]    r_pressed;
    logic [3:0]             r_cnt [NUM_KEYS];
    logic [NUM_ROWS-1:0]    r_pend;
    logic [1:0]             r_pcol;
    logic                   r_ovf;

    logic                   w_sample;
    logic [NUM_ROWS-1:0]    w_row;
    logic [NUM_ROWS-1:0]    w_raw;
    key_code_t              w_key [NUM_ROWS];
    logic [NUM_ROWS-1:0]    w_state;
    logic [3:0]             w_cnt_inc [NUM_ROWS];
    logic [NUM_ROWS-1:0]    w_flip;
    logic [NUM_ROWS-1:0]    w_newpress;
    logic [1:0]             w_prow;
    logic                   w_push;
    key_code_t              w_push_code;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    key_code_t              w_head;

    assign w_sample       = (r_div == DW'(SCAN_DIV - 1));
    assign key_matrix_col = ~(3'b001 << r_col);

`ifdef WAM_ROW_SYNC_EN
    logic [NUM_ROWS-1:0] r_sync1;
    logic [NUM_ROWS-1:0] r_sync2;

    // Two-flop synchronizer for the asynchronous row returns.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= key_matrix_row;
            r_sync2 <= r_sync1;
        end
    end
    assign w_row = r_sync2;
`else
    assign w_row = key_matrix_row;
`endif

    // Column divider: each column is strobed for SCAN_DIV cycles, wrapping 2->0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
            r_col <= '0;
        end else if (w_sample) begin
            r_div <= '0;
            r_col <= (r_col == 2'(NUM_COLS - 1)) ? 2'd0 : r_col + 2'd1;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    // Per-row view of the three keys on the active column.
    always_comb begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            w_raw[r]      = ~w_row[r];
            w_key[r]      = key_index(2'(r), r_col);
            w_state[r]    = r_pressed[w_key[r]];
            w_cnt_inc[r]  = r_cnt[w_key[r]] + 4'd1;
            w_flip[r]     = (w_raw[r] != w_state[r]) && (w_cnt_inc[r] == 4'(DEBOUNCE_SCANS));
            w_newpress[r] = w_flip[r] & w_raw[r];
        end
    end

    // Lowest pending row is pushed first.
    always_comb begin
        w_prow = 2'd0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (r_pend[r]) w_prow = 2'(r);
        end
    end

    assign w_push      = |r_pend;
    assign w_push_code = key_index(w_prow, r_pcol);

    // Debounce update at each sample, and the pending-press queue it feeds.
    // At most three presses per sample and SCAN_DIV >= 4, so r_pend is
    // always drained before the next sample overwrites it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pressed <= '0;
            for (int k = 0; k < NUM_KEYS; k++) r_cnt[k] <= '0;
            r_pend    <= '0;
            r_pcol    <= '0;
        end else if (w_sample) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
                if (w_raw[r] != w_state[r]) begin
                    if (w_flip[r]) begin
                        r_pressed[w_key[r]] <= w_raw[r];
                        r_cnt[w_key[r]]     <= '0;
                    end else begin
                        r_cnt[w_key[r]]     <= w_cnt_inc[r];
                    end
                end else begin
                    r_cnt[w_key[r]] <= '0;
                end
            end
            r_pend <= w_newpress;
            r_pcol <= r_col;
        end else begin
            r_pend <= r_pend & ~(3'b001 << w_prow);
        end
    end

    assign w_pop = key_valid & key_ready;

    // Sticky overflow: a push found the FIFO full with no pop to make room.
    always_ff @(posedge clk) begin
        if (reset)                          r_ovf <= 1'b0;
        else if (w_push & w_full & ~w_pop)  r_ovf <= 1'b1;
    end

    key_event_fifo u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (w_push),
        .data_in  (w_push_code),
        .full     (w_full),
        .pop      (w_pop),
        .data_out (w_head),
        .empty    (w_empty)
    );

    assign key_valid    = ~w_empty;
    assign key_code     = w_head;
    assign key_overflow = r_ovf;

endmodule
